tlb_op_sequencer: RTL and testbench

//  Sequences committed TLB maintenance instructions (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB) from writeback onto the TLB array and the CSR file.
//  - Produces the CSR capture strobes (s1e/s1_index/s1_ne, re) and the TLB write/clear strobes.
//  - Walks the array one entry per cycle for INVTLB.
//  - Requests a refetch of pc+4 when each op completes.
//  - Sits between the writeback stage and the csr_/TLB pair.

---
 rtl/tlb_op_sequencer_if.sv | 46 ++++
 rtl/tlb_op_sequencer.sv | 91 +++++++++
 tb/tb_tlb_op_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/tlb_op_sequencer_if.sv
// tlb_op_sequencer_if: writeback/CSR/TLB-side bundle of the TLB op sequencer
// master = writeback stage, CSR file and TLB array; slave = sequencer
`timescale 1ns/1ps
interface tlb_op_sequencer_if #(parameter int TLBNUMSIZE = 4);
  logic                  op_valid;
  logic                  op_ready;
  logic [2:0]            op_code;
  logic [4:0]            inv_op;
  logic [9:0]            inv_asid;
  logic [18:0]           inv_vppn;
  logic [TLBNUMSIZE-1:0] csr_idx;
  logic [18:0]           csr_vppn;
  logic [9:0]            csr_asid;
  logic [18:0]           s_vppn;
  logic [9:0]            s_asid;
  logic                  s_found;
  logic [TLBNUMSIZE-1:0] s_index;
  logic                  s1e;
  logic [TLBNUMSIZE-1:0] s1_index;
  logic                  s1_ne;
  logic                  re;
  logic                  tlb_we;
  logic [TLBNUMSIZE-1:0] tlb_w_index;
  logic [TLBNUMSIZE-1:0] walk_index;
  logic                  walk_e;
  logic                  walk_g;
  logic [5:0]            walk_ps;
  logic [9:0]            walk_asid;
  logic [18:0]           walk_vppn;
  logic                  clr_we;
  logic                  inv_err;
  logic                  done;
  logic                  refetch;
  modport master (
    output op_valid, op_code, inv_op, inv_asid, inv_vppn, csr_idx, csr_vppn, csr_asid,
           s_found, s_index, walk_e, walk_g, walk_ps, walk_asid, walk_vppn,
    input  op_ready, s_vppn, s_asid, s1e, s1_index, s1_ne, re, tlb_we, tlb_w_index,
           walk_index, clr_we, inv_err, done, refetch
  );
  modport slave (
    input  op_valid, op_code, inv_op, inv_asid, inv_vppn, csr_idx, csr_vppn, csr_asid,
           s_found, s_index, walk_e, walk_g, walk_ps, walk_asid, walk_vppn,
    output op_ready, s_vppn, s_asid, s1e, s1_index, s1_ne, re, tlb_we, tlb_w_index,
           walk_index, clr_we, inv_err, done, refetch
  );
endinterface

// File: rtl/tlb_op_sequencer.sv
// tlb_op_sequencer: steps committed TLBSRCH/RD/WR/FILL/INVTLB ops onto the TLB array and CSR file
// ports: clk, reset (sync, active-high), bus (tlb_op_sequencer_if.slave: op handshake,
// CSR keys, TLB search/walk inputs, CSR/TLB strobes, done/refetch/inv_err pulses)
`timescale 1ns/1ps
module tlb_op_sequencer #(
  parameter int TLBNUM     = 16,
  parameter int TLBNUMSIZE = 4
) (
  input logic clk,
  input logic reset,
  tlb_op_sequencer_if.slave bus
);
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SRCH    = 3'd1;
  localparam logic [2:0] ST_SRCH_WB = 3'd2;
  localparam logic [2:0] ST_RD      = 3'd3;
  localparam logic [2:0] ST_WR      = 3'd4;
  localparam logic [2:0] ST_INV     = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;
  logic [2:0]            r_state;
  logic [TLBNUMSIZE-1:0] r_fill, r_widx, r_walk, r_sidx;
  logic                  r_found, r_err;
  logic [4:0]            r_inv_op;
  logic [9:0]            r_inv_asid, r_csr_asid;
  logic [18:0]           r_inv_vppn, r_csr_vppn;
  logic [2:0]            w_next, w_start;
  logic                  w_acc, w_err, w_last, w_asid_m, w_va_m, w_match;
  assign w_acc   = bus.op_valid & bus.op_ready;
  assign w_err   = bus.op_code > 3'd4 || (bus.op_code == 3'd4 && bus.inv_op > 5'd6);
  assign w_last  = r_walk == TLBNUMSIZE'(TLBNUM - 1);
  assign w_start = w_err                 ? ST_DONE :
                   bus.op_code == 3'd0   ? ST_SRCH :
                   bus.op_code == 3'd1   ? ST_RD   :
                   bus.op_code == 3'd4   ? ST_INV  : ST_WR;
  // SRCH_WB, RD and WR all fall through to DONE after their single strobe cycle
  assign w_next  = r_state == ST_IDLE ? (w_acc ? w_start : ST_IDLE) :
                   r_state == ST_SRCH ? ST_SRCH_WB :
                   r_state == ST_INV  ? (w_last ? ST_DONE : ST_INV) :
                   r_state == ST_DONE ? ST_IDLE : ST_DONE;
  // ps=21 pages compare only the upper vppn bits
  assign w_asid_m = bus.walk_asid == r_inv_asid;
  assign w_va_m   = (bus.walk_ps == 6'd12 && bus.walk_vppn == r_inv_vppn) ||
                    (bus.walk_ps == 6'd21 && bus.walk_vppn[18:9] == r_inv_vppn[18:9]);
  assign w_match  = r_inv_op <= 5'd1 ? 1'b1 :
                    r_inv_op == 5'd2 ? bus.walk_g :
                    r_inv_op == 5'd3 ? ~bus.walk_g :
                    r_inv_op == 5'd4 ? ~bus.walk_g & w_asid_m :
                    r_inv_op == 5'd5 ? ~bus.walk_g & w_asid_m & w_va_m :
                                       (bus.walk_g | w_asid_m) & w_va_m;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_fill  <= '0;
      r_walk  <= '0;
      r_err   <= 1'b0;
      r_found <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fill  <= r_fill + 1'b1;
      if (w_acc) begin
        r_inv_op   <= bus.inv_op;
        r_inv_asid <= bus.inv_asid;
        r_inv_vppn <= bus.inv_vppn;
        r_csr_vppn <= bus.csr_vppn;
        r_csr_asid <= bus.csr_asid;
        r_widx     <= bus.op_code == 3'd3 ? r_fill : bus.csr_idx;
        r_err      <= w_err;
        r_walk     <= '0;
      end
      if (r_state == ST_SRCH) begin
        r_found <= bus.s_found;
        r_sidx  <= bus.s_index;
      end
      if (r_state == ST_INV) r_walk <= r_walk + 1'b1;
    end
  end
  assign bus.op_ready    = r_state == ST_IDLE && !reset;
  assign bus.s_vppn      = r_csr_vppn;
  assign bus.s_asid      = r_csr_asid;
  assign bus.s1e         = r_state == ST_SRCH_WB;
  assign bus.s1_index    = r_found ? r_sidx : '0;
  assign bus.s1_ne       = ~r_found;
  assign bus.re          = r_state == ST_RD;
  assign bus.tlb_we      = r_state == ST_WR;
  assign bus.tlb_w_index = r_widx;
  assign bus.walk_index  = r_walk;
  assign bus.clr_we      = r_state == ST_INV && bus.walk_e && w_match;
  assign bus.done        = r_state == ST_DONE;
  assign bus.refetch     = r_state == ST_DONE;
  assign bus.inv_err     = r_state == ST_DONE && r_err;
endmodule

// File: tb/tb_tlb_op_sequencer.sv
// tb_tlb_op_sequencer: directed self-checking bench for tlb_op_sequencer
`timescale 1ns/1ps
module tb_tlb_op_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic        e_arr[16];
  logic        g_arr[16];
  logic [5:0]  ps_arr[16];
  logic [9:0]  asid_arr[16];
  logic [18:0] vppn_arr[16];
  tlb_op_sequencer_if #(.TLBNUMSIZE(4)) bus();
  tlb_op_sequencer #(.TLBNUM(16), .TLBNUMSIZE(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
  always_comb begin
    bus.walk_e    = e_arr[bus.walk_index];
    bus.walk_g    = g_arr[bus.walk_index];
    bus.walk_ps   = ps_arr[bus.walk_index];
    bus.walk_asid = asid_arr[bus.walk_index];
    bus.walk_vppn = vppn_arr[bus.walk_index];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic issue(input logic [2:0] code, input logic [4:0] iop);
    chk("ready_before_issue", bus.op_ready, 1);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.inv_op   = iop;
    tick();
    bus.op_valid = 1'b0;
  endtask
  task automatic clear_tlb();
    for (int i = 0; i < 16; i++) begin
      e_arr[i] = 0; g_arr[i] = 0; ps_arr[i] = 6'd12; asid_arr[i] = '0; vppn_arr[i] = '0;
    end
  endtask
  task automatic set_ent(input int i, input logic g, input logic [5:0] ps, input logic [9:0] asid, input logic [18:0] vppn);
    e_arr[i] = 1'b1; g_arr[i] = g; ps_arr[i] = ps; asid_arr[i] = asid; vppn_arr[i] = vppn;
  endtask
  task automatic walk_check(input string tag, input logic [15:0] exp_mask);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_walk_idx%0d", tag, k), bus.walk_index, k);
      chk($sformatf("%s_clr%0d", tag, k), bus.clr_we, exp_mask[k]);
      chk($sformatf("%s_nodone%0d", tag, k), bus.done, 0);
      tick();
    end
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_refetch"}, bus.refetch, 1);
    chk({tag, "_clr_at_done"}, bus.clr_we, 0);
    chk({tag, "_noerr"}, bus.inv_err, 0);
    tick();
    chk({tag, "_ready_after"}, bus.op_ready, 1);
  endtask
  initial begin
    bus.op_valid = 0; bus.op_code = 0; bus.inv_op = 0; bus.inv_asid = 0; bus.inv_vppn = 0;
    bus.csr_idx = 0; bus.csr_vppn = 0; bus.csr_asid = 0; bus.s_found = 0; bus.s_index = 0;
    clear_tlb();
    tick(); tick();
    chk("rst_ready", bus.op_ready, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_refetch", bus.refetch, 0);
    chk("rst_s1e", bus.s1e, 0);
    chk("rst_re", bus.re, 0);
    chk("rst_we", bus.tlb_we, 0);
    chk("rst_clr", bus.clr_we, 0);
    chk("rst_err", bus.inv_err, 0);
    chk("rst_walk", bus.walk_index, 0);
    reset = 1'b0;
    tick();
    chk("idle_ready", bus.op_ready, 1);
    // SRCH hit
    bus.csr_vppn = 19'h12345; bus.csr_asid = 10'h3; bus.s_found = 1; bus.s_index = 4'd7;
    issue(3'd0, 5'd0);
    chk("srch_vppn", bus.s_vppn, 19'h12345);
    chk("srch_asid", bus.s_asid, 10'h3);
    chk("srch_t1_s1e", bus.s1e, 0);
    tick();
    chk("srch_s1e", bus.s1e, 1);
    chk("srch_idx", bus.s1_index, 7);
    chk("srch_ne", bus.s1_ne, 0);
    chk("srch_t2_done", bus.done, 0);
    tick();
    chk("srch_done", bus.done, 1);
    chk("srch_refetch", bus.refetch, 1);
    chk("srch_t3_s1e", bus.s1e, 0);
    tick();
    chk("srch_done_low", bus.done, 0);
    // SRCH miss
    bus.s_found = 0; bus.s_index = 4'd5;
    issue(3'd0, 5'd0);
    tick();
    chk("miss_s1e", bus.s1e, 1);
    chk("miss_ne", bus.s1_ne, 1);
    chk("miss_idx", bus.s1_index, 0);
    tick();
    chk("miss_done", bus.done, 1);
    tick();
    // RD
    issue(3'd1, 5'd0);
    chk("rd_re", bus.re, 1);
    chk("rd_we", bus.tlb_we, 0);
    tick();
    chk("rd_re_low", bus.re, 0);
    chk("rd_done", bus.done, 1);
    tick();
    // WR
    bus.csr_idx = 4'd5;
    issue(3'd2, 5'd0);
    chk("wr_we", bus.tlb_we, 1);
    chk("wr_idx", bus.tlb_w_index, 5);
    tick();
    chk("wr_we_low", bus.tlb_we, 0);
    chk("wr_done", bus.done, 1);
    tick();
    // FILL at counter 15, bounded wait for the counter to reach it
    begin
      int w;
      w = 0;
      while ((cyc % 16) != 15 && w < 20) begin tick(); w++; end
      chk("fill_wait", (cyc % 16) == 15, 1);
    end
    bus.csr_idx = 4'd2;
    issue(3'd3, 5'd0);
    chk("fill_we", bus.tlb_we, 1);
    chk("fill_idx15", bus.tlb_w_index, 15);
    tick();
    chk("fill_done", bus.done, 1);
    tick();
    // counter wrapped to 0 right after the accept, so two cycles later it reads 2
    issue(3'd3, 5'd0);
    chk("fill_wrap_idx", bus.tlb_w_index, 2);
    tick(); tick();
    // INV op 2: only global entries
    clear_tlb();
    set_ent(3, 1, 6'd12, 10'h1, 19'h1);
    set_ent(9, 1, 6'd21, 10'h2, 19'h2);
    set_ent(5, 0, 6'd12, 10'h1, 19'h1);
    g_arr[11] = 1;
    issue(3'd4, 5'd2);
    walk_check("inv2", 16'h0208);
    // INV op 5: asid 0x0A, vppn 0x55A00
    clear_tlb();
    bus.inv_asid = 10'h0A; bus.inv_vppn = 19'h55A00;
    set_ent(4, 0, 6'd21, 10'h0A, 19'h55BFF);
    set_ent(6, 1, 6'd21, 10'h0A, 19'h55BFF);
    set_ent(8, 0, 6'd12, 10'h0A, 19'h55A01);
    set_ent(10, 0, 6'd12, 10'h0A, 19'h55A00);
    set_ent(12, 0, 6'd12, 10'h0B, 19'h55A00);
    issue(3'd4, 5'd5);
    walk_check("inv5", 16'h0410);
    // INV op 6: global or asid match, plus va match
    issue(3'd4, 5'd6);
    walk_check("inv6", 16'h0450);
    // illegal inv_op
    issue(3'd4, 5'd7);
    chk("err7_done", bus.done, 1);
    chk("err7_err", bus.inv_err, 1);
    chk("err7_refetch", bus.refetch, 1);
    chk("err7_clr", bus.clr_we, 0);
    tick();
    chk("err7_err_low", bus.inv_err, 0);
    chk("err7_ready", bus.op_ready, 1);
    // illegal op_code
    issue(3'd6, 5'd0);
    chk("code6_done", bus.done, 1);
    chk("code6_err", bus.inv_err, 1);
    tick();
    // reset during INV walk
    clear_tlb();
    for (int i = 0; i < 16; i++) e_arr[i] = 1;
    issue(3'd4, 5'd0);
    tick(); tick(); tick();
    chk("abort_walk3", bus.walk_index, 3);
    chk("abort_clr3", bus.clr_we, 1);
    reset = 1'b1;
    #1;
    chk("abort_ready_in_rst", bus.op_ready, 0);
    tick();
    chk("abort_done", bus.done, 0);
    chk("abort_clr", bus.clr_we, 0);
    chk("abort_walk", bus.walk_index, 0);
    reset = 1'b0;
    tick();
    chk("abort_ready", bus.op_ready, 1);
    chk("abort_done2", bus.done, 0);
    chk("abort_refetch", bus.refetch, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  always @(negedge clk)
    if (!reset && (int'(bus.s1e) + int'(bus.re) + int'(bus.tlb_we) + int'(bus.clr_we)) > 1) begin
      n_chk++;
      n_fail++;
      $display("FAIL strobe_excl: s1e=%0b re=%0b we=%0b clr=%0b expected at most one", bus.s1e, bus.re, bus.tlb_we, bus.clr_we);
    end
endmodule
